// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequencer for an external combinational ALU, with a small
// register file and stored Z/C flags.
// Each command takes three cycles: IDLE (accept and read operands),
// EXEC (drive the ALU and capture its result), then WB (done pulse).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid / cmd_ready       command handshake (ready only in IDLE)
//   cmd_op, cmd_rs1/rs2/rd      opcode, source and destination registers
//   cmd_imm, cmd_usec, cmd_fin  immediate, flag-in select, explicit flag-in
//   ALUA/ALUB/ALUcontrol/ALUFLAGin   outputs to the ALU (zero outside EXEC)
//   ALUresult, ALUflags {Z,C}   results returned by the ALU
//   done, resp_data, err        completion pulse, result and illegal-op pulse
//   flag_z, flag_c              stored flags
//   dbg_addr / dbg_data         combinational register read port
module alu_seq_ctrl #(
  parameter int n    = 4,
  parameter int NREG = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [2:0]   cmd_rs1,
  input  logic [2:0]   cmd_rs2,
  input  logic [2:0]   cmd_rd,
  input  logic [n-1:0] cmd_imm,
  input  logic         cmd_usec,
  input  logic         cmd_fin,
  output logic [n-1:0] ALUA,
  output logic [n-1:0] ALUB,
  output logic [3:0]   ALUcontrol,
  output logic         ALUFLAGin,
  input  logic [n-1:0] ALUresult,
  input  logic [1:0]   ALUflags,
  output logic         done,
  output logic [n-1:0] resp_data,
  output logic         flag_z,
  output logic         flag_c,
  output logic         err,
  input  logic [2:0]   dbg_addr,
  output logic [n-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t       state_q, state_d;
  logic [3:0]   op_q, op_d;
  logic [2:0]   rd_q, rd_d;
  logic [n-1:0] imm_q, imm_d;
  logic [n-1:0] a_q, a_d;
  logic [n-1:0] b_q, b_d;
  logic         fin_q, fin_d;
  logic [n-1:0] res_q, res_d;
  logic         fz_q, fz_d;
  logic         fc_q, fc_d;
  logic [n-1:0] regs_q [NREG];
  logic [n-1:0] regs_d [NREG];

  logic [n-1:0] rs1_val, rs2_val;
  logic         op_alu, op_ldi;

  // Register reads; addresses beyond NREG read as zero.
  always_comb begin
    rs1_val  = '0;
    rs2_val  = '0;
    dbg_data = '0;
    if (int'(cmd_rs1) < NREG) rs1_val = regs_q[cmd_rs1];
    if (int'(cmd_rs2) < NREG) rs2_val = regs_q[cmd_rs2];
    if (int'(dbg_addr) < NREG) dbg_data = regs_q[dbg_addr];
  end

  assign op_alu = (op_q < 4'hA);
  assign op_ldi = (op_q == 4'hF);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    a_d     = a_q;
    b_d     = b_q;
    fin_d   = fin_q;
    res_d   = res_q;
    fz_d    = fz_q;
    fc_d    = fc_q;
    regs_d  = regs_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          rd_d    = cmd_rd;
          imm_d   = cmd_imm;
          a_d     = rs1_val;
          b_d     = rs2_val;
          // Flag-in is resolved at acceptance so a later carry update
          // cannot leak into this command.
          fin_d   = cmd_usec ? fc_q : cmd_fin;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d = '0;
        if (op_alu) begin
          res_d = ALUresult;
          fz_d  = ALUflags[1];
          fc_d  = ALUflags[0];
          if (int'(rd_q) < NREG) regs_d[rd_q] = ALUresult;
        end else if (op_ldi) begin
          res_d = imm_q;
          fz_d  = (imm_q == '0);
          if (int'(rd_q) < NREG) regs_d[rd_q] = imm_q;
        end
        state_d = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fin_q   <= 1'b0;
      res_q   <= '0;
      fz_q    <= 1'b0;
      fc_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fin_q   <= fin_d;
      res_q   <= res_d;
      fz_q    <= fz_d;
      fc_q    <= fc_d;
      regs_q  <= regs_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign done       = (state_q == WB);
  assign err        = done && !op_alu && !op_ldi;
  assign resp_data  = done ? res_q : '0;
  assign flag_z     = fz_q;
  assign flag_c     = fc_q;

  assign ALUA       = (state_q == EXEC) ? a_q   : '0;
  assign ALUB       = (state_q == EXEC) ? b_q   : '0;
  assign ALUcontrol = (state_q == EXEC) ? op_q  : 4'h0;
  assign ALUFLAGin  = (state_q == EXEC) ? fin_q : 1'b0;

endmodule
